// File: rtl/toy_dmem_responder_pkg.sv
// Shared types and constants for the RISC_TOY data-memory responder.
package toy_mem_pkg;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  localparam logic [1:0] MMIO_CYCLE   = 2'd0;
  localparam logic [1:0] MMIO_HALT    = 2'd1;
  localparam logic [1:0] MMIO_SCRATCH = 2'd2;

  // DADDR bit that selects the MMIO window
  localparam int MMIO_SEL_BIT = 29;

endpackage

// File: rtl/toy_dmem_responder_if.sv
// Core data-memory bus: the core is master, the responder is slave.
interface toy_dmem_responder_if;
  logic        DREQ;
  logic        DRW;
  logic [29:0] DADDR;
  logic [31:0] DWDATA;
  logic [31:0] DRDATA;

  modport master (output DREQ, DRW, DADDR, DWDATA, input DRDATA);
  modport slave  (input DREQ, DRW, DADDR, DWDATA, output DRDATA);
endinterface

// File: rtl/toy_spram.sv
// Single-port synchronous word RAM; registered read of the addressed word.
module toy_spram #(
  parameter int AW = 10
) (
  input  logic          CLK,
  input  logic          WE,
  input  logic [AW-1:0] A,
  input  logic [31:0]   D,
  output logic [31:0]   Q
);
  logic [31:0] mem [2**AW];

  // write port plus registered read (old data on a same-cycle write)
  always_ff @(posedge CLK) begin
    if (WE) mem[A] <= D;
    Q <= mem[A];
  end
endmodule

// File: rtl/toy_dmem_responder.sv
// Data-memory responder: clears RAM after reset while holding the core in
// reset, then serves single-cycle RAM/MMIO reads and writes.
module toy_dmem_responder
  import toy_mem_pkg::*;
#(
  parameter int          AW        = 10,
  parameter logic [31:0] CLEAR_VAL = 32'h0
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  toy_dmem_responder_if.slave  dbus,
  output logic                 CORE_RSTN,
  output logic                 INIT_DONE,
  output logic                 HALT,
  output logic [31:0]          HALT_CODE,
  output logic                 ERR
);
  localparam logic [AW-1:0] LAST_ADDR = '1;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_q, clr_d;
  logic [31:0]   cycle_q, cycle_d;
  logic [31:0]   scratch_q, scratch_d;
  logic [31:0]   halt_code_q, halt_code_d;
  logic          err_q, err_d;
  logic          init_q, init_d;
  logic [31:0]   dout_q, dout_d;   // held read data for non-RAM reads / idles
  logic          rsel_q, rsel_d;   // last cycle was a RAM read: show RAM Q

  logic          ram_we;
  logic [AW-1:0] ram_a;
  logic [31:0]   ram_d, ram_q;
  logic [28:0]   addr_lo;
  logic          is_ram, is_mmio, run;
  logic [31:0]   mmio_rd, drdata;

  toy_spram #(.AW(AW)) u_ram (
    .CLK (CLK),
    .WE  (ram_we),
    .A   (ram_a),
    .D   (ram_d),
    .Q   (ram_q)
  );

  // address decode and MMIO read mux
  always_comb begin
    addr_lo = dbus.DADDR[28:0];
    is_ram  = !dbus.DADDR[MMIO_SEL_BIT] && ((addr_lo >> AW) == '0);
    is_mmio = dbus.DADDR[MMIO_SEL_BIT] && (dbus.DADDR[28:2] == '0);
    run     = (state_q == S_RUN);
    case (dbus.DADDR[1:0])
      MMIO_CYCLE:   mmio_rd = cycle_q;
      MMIO_SCRATCH: mmio_rd = scratch_q;
      default:      mmio_rd = '0;
    endcase
    // RAM reads come straight from the RAM's output register for one cycle
    drdata = rsel_q ? ram_q : dout_q;
  end

  // next-state: clear engine, request handling, MMIO side effects
  always_comb begin
    state_d     = state_q;
    clr_d       = clr_q;
    cycle_d     = cycle_q;
    scratch_d   = scratch_q;
    halt_code_d = halt_code_q;
    err_d       = err_q;
    init_d      = init_q;
    dout_d      = drdata;
    rsel_d      = 1'b0;
    ram_we      = 1'b0;
    ram_a       = dbus.DADDR[AW-1:0];
    ram_d       = dbus.DWDATA;
    if (state_q == S_CLEAR) begin
      ram_we = 1'b1;
      ram_a  = clr_q;
      ram_d  = CLEAR_VAL;
      clr_d  = clr_q + 1'b1;
      if (clr_q == LAST_ADDR) begin
        state_d = S_RUN;
        init_d  = 1'b1;
      end
    end else begin
      if (run) cycle_d = cycle_q + 32'd1;
      if (dbus.DREQ) begin
        if (is_ram) begin
          if (dbus.DRW) ram_we = run;
          else          rsel_d = 1'b1;
        end else if (is_mmio) begin
          if (dbus.DRW) begin
            if (run && dbus.DADDR[1:0] == MMIO_HALT) begin
              state_d     = S_HALT;
              halt_code_d = dbus.DWDATA;
            end
            if (run && dbus.DADDR[1:0] == MMIO_SCRATCH) scratch_d = dbus.DWDATA;
          end else begin
            dout_d = mmio_rd;
          end
        end else begin
          err_d = 1'b1;
          if (!dbus.DRW) dout_d = '0;
        end
      end
    end
  end

  // state register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= S_CLEAR;
      clr_q       <= '0;
      cycle_q     <= '0;
      scratch_q   <= '0;
      halt_code_q <= '0;
      err_q       <= 1'b0;
      init_q      <= 1'b0;
      dout_q      <= '0;
      rsel_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      cycle_q     <= cycle_d;
      scratch_q   <= scratch_d;
      halt_code_q <= halt_code_d;
      err_q       <= err_d;
      init_q      <= init_d;
      dout_q      <= dout_d;
      rsel_q      <= rsel_d;
    end
  end

  assign dbus.DRDATA = drdata;
  assign CORE_RSTN   = init_q;
  assign INIT_DONE   = init_q;
  assign HALT        = (state_q == S_HALT);
  assign HALT_CODE   = halt_code_q;
  assign ERR         = err_q;
endmodule

// File: doc/toy_dmem_responder.md
# toy_dmem_responder

Data-memory responder for the RISC_TOY core: the memory-side end of the core's DREQ/DRW/DADDR/DWDATA/DRDATA port. After reset it clears its word array, holding the core in reset until clearing finishes. It then serves single-cycle word reads and writes. It also exposes three memory-mapped registers: a cycle counter, a halt/exit register and a scratch word. It sits beside the core in the testbench/SoC top and drives the core's reset.

## Interface

Parameters:
- AW, 10: word-address bits of the RAM; DEPTH = 2^AW words.
- CLEAR_VAL, 32'h0: value written to every word during clearing.

Ports:
- CLK, input, 1: clock; all logic is on the rising edge.
- RSTN, input, 1: reset, asynchronous and active-low.
- DREQ, input, 1: request valid this cycle.
- DRW, input, 1: 1 = write, 0 = read; sampled only when DREQ = 1.
- DADDR, input, 30: word address.
- DWDATA, input, 32: write data.
- DRDATA, output, 32: read data, registered.
- CORE_RSTN, output, 1: active-low reset to the core, registered.
- INIT_DONE, output, 1: clearing has finished.
- HALT, output, 1: sticky; set by a write to the HALT register.
- HALT_CODE, output, 32: data from the first HALT write.
- ERR, output, 1: sticky; set by an access to an unmapped address.

## Operation

Address map:
- DADDR[29] = 0 and DADDR[28:AW] = 0: RAM word DADDR[AW-1:0].
- DADDR[29] = 1, DADDR[28:2] = 0: MMIO register DADDR[1:0].
  - 0 = CYCLE, read-only.
  - 1 = HALT, write-only; reads return 0.
  - 2 = SCRATCH, read/write.
  - 3 = reserved; reads return 0, writes are dropped.
- Any other address is unmapped: reads return 0, writes are dropped, ERR is set.

State machine:
- CLEAR: entered on reset. A clear counter walks addresses 0..DEPTH-1, writing CLEAR_VAL at one word per cycle. After writing address DEPTH-1, the machine moves to RUN. All DREQ input is ignored in this state.
- RUN: serves requests. A write to HALT moves the machine to HALT and latches HALT_CODE.
- HALT: RAM and SCRATCH writes are dropped; reads are still served; further HALT writes are ignored and HALT_CODE keeps its first value; the machine leaves this state only on reset.

CYCLE register:
- Increments by 1 every cycle in RUN.
- Freezes in CLEAR and HALT.
- Wraps 32'hFFFF_FFFF -> 0 with no flag.

Reads and writes:
- A read to a location that was written on the previous cycle returns the new data (single-port RAM; no read-during-write hazard exists because there is one request per cycle).
- A read returns the CYCLE value sampled in the request cycle.

## Timing

Reset values:
- DRDATA = 0, CORE_RSTN = 0, INIT_DONE = 0, HALT = 0, HALT_CODE = 0, ERR = 0.
- CYCLE = 0, SCRATCH = 0, clear counter = 0, state = CLEAR.

Clearing:
- Takes exactly DEPTH cycles after RSTN deasserts.
- INIT_DONE and CORE_RSTN rise together on the edge that ends the last clear write.

Reads:
- Read latency is 1: a read sampled on edge N drives DRDATA after edge N.
- DRDATA is stable through cycle N+1.
- DRDATA holds its value through writes and idle cycles; only a read updates it.

Writes:
- A write is complete at the sampling edge and is visible to a read on the next edge.

Flags and reset behaviour:
- ERR and HALT set on the edge that samples the offending or halting request.
- Asserting RSTN mid-operation immediately forces all reset values, including CORE_RSTN = 0.
- RAM contents are not reset asynchronously; they are overwritten by the following CLEAR pass.

## Structure

Package toy_mem_pkg holds:
- State encoding: CLEAR, RUN, HALT.
- MMIO offsets: MMIO_CYCLE = 2'd0, MMIO_HALT = 2'd1, MMIO_SCRATCH = 2'd2.
- MMIO select bit index 29.

Sub-module toy_spram:
- Single-port synchronous RAM with parameter AW and inputs CLK, WE, A, D.
- Output Q is registered.
- No reset on the array.
- Used for the RAM storage.
- The clear engine drives its write port in CLEAR; the request path drives it in RUN.

## Test plan

Run all scenarios with AW = 4.

- Reset release: CORE_RSTN and INIT_DONE stay 0 for 16 cycles, then rise. Reading words 0..15 returns CLEAR_VAL.
- Read after write: write 32'hCAFE_0001 to word 5, then read word 5 on the next cycle. DRDATA = 32'hCAFE_0001 one cycle after the read, and is unchanged by a following write to word 6.
- MMIO:
  - Read CYCLE twice, 3 cycles apart: values differ by 3.
  - Write SCRATCH = 32'h1234_5678, then read it back: returns 32'h1234_5678.
  - Read HALT: returns 0.
- Unmapped access: write to DADDR = 30'h0000_0010 (beyond AW = 4). ERR = 1, word 0 is unchanged. A read of 30'h2000_0007 returns 0.
- Halt:
  - Write HALT = 32'h0000_0042: HALT = 1, HALT_CODE = 0x42.
  - Write word 2 = 0x55: a read of word 2 still returns CLEAR_VAL.
  - Write HALT = 0x99: HALT_CODE stays 0x42.
  - CYCLE stays frozen.
- Mid-run reset: pulse RSTN low during RUN with HALT = 1. All outputs return to their reset values, then a full 16-cycle CLEAR pass runs. The word written before the reset reads CLEAR_VAL.
